univ_shift_reg: RTL and testbench



---
 rtl/univ_shift_reg.sv | 138 +++++++++++++
 tb/tb_univ_shift_reg.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal register with true/complement outputs,
// eight operations (hold, shift left/right, rotate left/right, load, clear,
// invert), serial in/out at both ends and a saturating shift counter.
//
// Parameters:
//   WIDTH      register width in bits (2..64)
//   RESET_VAL  value of Q on reset and after CLEAR
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         operation enable; low holds all state
//   mode       operation select (3 bits)
//   D          parallel load data
//   sin_r      serial input entering bit 0 on shift left
//   sin_l      serial input entering bit WIDTH-1 on shift right
//   Q          registered contents
//   Qb         registered complement of Q (separate register)
//   sout_l     Q[WIDTH-1], combinational
//   sout_r     Q[0], combinational
//   shift_cnt  shifts/rotates since last load/clear, saturating at WIDTH
//   cnt_full   registered (shift_cnt == WIDTH)
//   par        registered ^Q; present only when UNIV_SHIFT_REG_PARITY_EN is defined
module univ_shift_reg #(
   parameter int unsigned          WIDTH     = 8,
   parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           en,
   input  logic [2:0]                     mode,
   input  logic [WIDTH-1:0]               D,
   input  logic                           sin_r,
   input  logic                           sin_l,
   output logic [WIDTH-1:0]               Q,
   output logic [WIDTH-1:0]               Qb,
   output logic                           sout_l,
   output logic                           sout_r,
   output logic [$clog2(WIDTH+1)-1:0]     shift_cnt,
   output logic                           cnt_full
`ifdef UNIV_SHIFT_REG_PARITY_EN
   ,
   output logic                           par
`endif
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   localparam logic [2:0] MODE_HOLD  = 3'b000;
   localparam logic [2:0] MODE_SHL   = 3'b001;
   localparam logic [2:0] MODE_SHR   = 3'b010;
   localparam logic [2:0] MODE_ROL   = 3'b011;
   localparam logic [2:0] MODE_ROR   = 3'b100;
   localparam logic [2:0] MODE_LOAD  = 3'b101;
   localparam logic [2:0] MODE_CLEAR = 3'b110;
   localparam logic [2:0] MODE_INV   = 3'b111;

   logic [WIDTH-1:0] q_nxt;
   logic [CW-1:0]    cnt_nxt;
   logic [CW-1:0]    cnt_inc;

   // Serial outputs tap the register directly
   assign sout_l = Q[WIDTH-1];
   assign sout_r = Q[0];

   // Next-state decode for contents and counter
   always_comb begin
      q_nxt   = Q;
      cnt_nxt = shift_cnt;
      cnt_inc = (shift_cnt == CW'(WIDTH)) ? shift_cnt : shift_cnt + CW'(1);
      if (en) begin
         case (mode)
            MODE_HOLD: begin
               q_nxt   = Q;
               cnt_nxt = shift_cnt;
            end
            MODE_SHL: begin
               q_nxt   = {Q[WIDTH-2:0], sin_r};
               cnt_nxt = cnt_inc;
            end
            MODE_SHR: begin
               q_nxt   = {sin_l, Q[WIDTH-1:1]};
               cnt_nxt = cnt_inc;
            end
            MODE_ROL: begin
               q_nxt   = {Q[WIDTH-2:0], Q[WIDTH-1]};
               cnt_nxt = cnt_inc;
            end
            MODE_ROR: begin
               q_nxt   = {Q[0], Q[WIDTH-1:1]};
               cnt_nxt = cnt_inc;
            end
            MODE_LOAD: begin
               q_nxt   = D;
               cnt_nxt = '0;
            end
            MODE_CLEAR: begin
               q_nxt   = RESET_VAL;
               cnt_nxt = '0;
            end
            MODE_INV: begin
               q_nxt   = ~Q;
               cnt_nxt = shift_cnt;
            end
            default: begin
               q_nxt   = Q;
               cnt_nxt = shift_cnt;
            end
         endcase
      end
   end

   // State registers; Qb and cnt_full are loaded from next-state values
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Q         <= RESET_VAL;
         Qb        <= ~RESET_VAL;
         shift_cnt <= '0;
         cnt_full  <= 1'b0;
      end else begin
         Q         <= q_nxt;
         Qb        <= ~q_nxt;
         shift_cnt <= cnt_nxt;
         cnt_full  <= (cnt_nxt == CW'(WIDTH));
      end
   end

`ifdef UNIV_SHIFT_REG_PARITY_EN
   // Parity tracks Q in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par <= ^RESET_VAL;
      end else begin
         par <= ^q_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Testbench for univ_shift_reg: two chained 8-bit instances (sout_l of the
// first drives sin_r of the second) checked every cycle against an
// arithmetic reference model, plus directed literal checks.
module tb_univ_shift_reg;

   localparam int unsigned W = 8;
   localparam logic [W-1:0] RV = 8'hA5;

   logic         clk;
   logic         rst_n;
   logic         en;
   logic [2:0]   mode;
   logic [W-1:0] d1, d2;
   logic         sin_r1, sin_l1, sin_l2;
   logic [W-1:0] q1, qb1, q2, qb2;
   logic         sl1, sr1, sl2, sr2;
   logic [3:0]   cnt1, cnt2;
   logic         full1, full2;
`ifdef UNIV_SHIFT_REG_PARITY_EN
   logic         par1, par2;
`endif

   int checks;
   int errors;
   bit chk_on;

   // Reference model state: contents as plain integers 0..255, counters 0..8
   int m1, m2, c1, c2;

   univ_shift_reg #(.WIDTH(W), .RESET_VAL(RV)) u_a (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .D(d1),
      .sin_r(sin_r1), .sin_l(sin_l1), .Q(q1), .Qb(qb1),
      .sout_l(sl1), .sout_r(sr1), .shift_cnt(cnt1), .cnt_full(full1)
`ifdef UNIV_SHIFT_REG_PARITY_EN
      , .par(par1)
`endif
   );

   univ_shift_reg #(.WIDTH(W), .RESET_VAL(RV)) u_b (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .D(d2),
      .sin_r(sl1), .sin_l(sin_l2), .Q(q2), .Qb(qb2),
      .sout_l(sl2), .sout_r(sr2), .shift_cnt(cnt2), .cnt_full(full2)
`ifdef UNIV_SHIFT_REG_PARITY_EN
      , .par(par2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Model of one register step in plain arithmetic
   function automatic void model_step(input int q, input int c, input int md,
                                      input int d, input int sr, input int sl,
                                      output int qn, output int cn);
      int inc;
      inc = (c + 1 > 8) ? 8 : c + 1;
      qn  = q;
      cn  = c;
      case (md)
         1: begin qn = (q * 2 + sr) % 256;           cn = inc; end
         2: begin qn = q / 2 + sl * 128;             cn = inc; end
         3: begin qn = (q * 2) % 256 + q / 128;      cn = inc; end
         4: begin qn = q / 2 + (q % 2) * 128;        cn = inc; end
         5: begin qn = d;                            cn = 0;   end
         6: begin qn = 'hA5;                         cn = 0;   end
         7: begin qn = 255 - q;                      cn = c;   end
         default: ;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int n1, n2, k1, k2, chain_in;
      if (!rst_n) begin
         m1 = 'hA5; m2 = 'hA5; c1 = 0; c2 = 0;
      end else if (en) begin
         chain_in = m1 / 128;
         model_step(m1, c1, int'(mode), int'(d1), int'(sin_r1), int'(sin_l1), n1, k1);
         model_step(m2, c2, int'(mode), int'(d2), chain_in, int'(sin_l2), n2, k2);
         m1 = n1; c1 = k1; m2 = n2; c2 = k2;
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_on) begin
         check("q_a",     longint'(q1),    longint'(m1));
         check("qb_a",    longint'(qb1),   longint'(255 - m1));
         check("soutl_a", longint'(sl1),   longint'(m1 / 128));
         check("soutr_a", longint'(sr1),   longint'(m1 % 2));
         check("cnt_a",   longint'(cnt1),  longint'(c1));
         check("full_a",  longint'(full1), longint'(c1 == 8));
         check("q_b",     longint'(q2),    longint'(m2));
         check("qb_b",    longint'(qb2),   longint'(255 - m2));
         check("cnt_b",   longint'(cnt2),  longint'(c2));
         check("full_b",  longint'(full2), longint'(c2 == 8));
`ifdef UNIV_SHIFT_REG_PARITY_EN
         check("par_a",   longint'(par1),  longint'($countones(m1[7:0]) % 2));
         check("par_b",   longint'(par2),  longint'($countones(m2[7:0]) % 2));
`endif
      end
   end

   // Drive one operation after a negedge, return after the following negedge
   task automatic op(input logic e, input logic [2:0] md, input logic [7:0] a,
                     input logic [7:0] b, input logic sr, input logic sl);
      en = e; mode = md; d1 = a; d2 = b; sin_r1 = sr; sin_l1 = sl; sin_l2 = ~sl;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      checks = 0; errors = 0; chk_on = 1'b0;
      m1 = 'hA5; m2 = 'hA5; c1 = 0; c2 = 0;
      rst_n = 1'b0; en = 1'b0; mode = 3'd0; d1 = '0; d2 = '0;
      sin_r1 = 1'b0; sin_l1 = 1'b0; sin_l2 = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_q",   longint'(q1),  longint'(8'hA5));
      check("rst_qb",  longint'(qb1), longint'(8'h5A));
      check("rst_cnt", longint'(cnt1), 0);
      rst_n = 1'b1;
      chk_on = 1'b1;

      // Asynchronous reset mid-cycle after a load
      op(1'b1, 3'd5, 8'h12, 8'h34, 1'b0, 1'b0);
      op(1'b1, 3'd1, 8'h00, 8'h00, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_q",    longint'(q1),    longint'(8'hA5));
      check("arst_qb",   longint'(qb1),   longint'(8'h5A));
      check("arst_cnt",  longint'(cnt1),  0);
      check("arst_full", longint'(full1), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // LOAD 81, ROL, ROR
      op(1'b1, 3'd5, 8'h81, 8'h00, 1'b0, 1'b0);
      op(1'b1, 3'd3, 8'h00, 8'h00, 1'b0, 1'b0);
      check("rol_q",     longint'(q1),   longint'(8'h03));
      check("rol_soutl", longint'(sl1),  0);
      check("rol_cnt",   longint'(cnt1), 1);
      op(1'b1, 3'd4, 8'h00, 8'h00, 1'b0, 1'b0);
      check("ror_q",   longint'(q1),   longint'(8'h81));
      check("ror_cnt", longint'(cnt1), 2);

      // Fill with ones via SHL; counter saturates
      op(1'b1, 3'd5, 8'h00, 8'h00, 1'b0, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         op(1'b1, 3'd1, 8'h00, 8'h00, 1'b1, 1'b0);
         if (i == 7) check("shl7_full", longint'(full1), 0);
         if (i >= 8) begin
            check("shl_q",    longint'(q1),    longint'(8'hFF));
            check("shl_cnt",  longint'(cnt1),  8);
            check("shl_full", longint'(full1), 1);
         end
      end
      op(1'b1, 3'd6, 8'h00, 8'h00, 1'b0, 1'b0);
      check("clr_q",    longint'(q1),    longint'(8'hA5));
      check("clr_cnt",  longint'(cnt1),  0);
      check("clr_full", longint'(full1), 0);

      // en low blocks a load
      for (int i = 0; i < 3; i++) begin
         op(1'b0, 3'd5, 8'h3C, 8'h3C, 1'b0, 1'b0);
         check("en0_q",   longint'(q1),  longint'(8'hA5));
         check("en0_qb",  longint'(qb1), longint'(8'h5A));
         check("en0_cnt", longint'(cnt1), 0);
      end
      op(1'b1, 3'd5, 8'h3C, 8'h3C, 1'b0, 1'b0);
      check("en1_q", longint'(q1), longint'(8'h3C));

      // INV keeps the counter
      op(1'b1, 3'd5, 8'hF0, 8'h00, 1'b0, 1'b0);
      op(1'b1, 3'd1, 8'h00, 8'h00, 1'b0, 1'b0);
      op(1'b1, 3'd7, 8'h00, 8'h00, 1'b0, 1'b0);
      check("inv_q",   longint'(q1),   longint'(8'h1F));
      check("inv_qb",  longint'(qb1),  longint'(8'hE0));
      check("inv_cnt", longint'(cnt1), 1);
      op(1'b1, 3'd5, 8'hF0, 8'h00, 1'b0, 1'b0);
      op(1'b1, 3'd7, 8'h00, 8'h00, 1'b0, 1'b0);
      check("inv2_q",  longint'(q1),  longint'(8'h0F));
      check("inv2_qb", longint'(qb1), longint'(8'hF0));

      // Serial chain: top bit of first moves into bit 0 of second
      op(1'b1, 3'd5, 8'h80, 8'h00, 1'b0, 1'b0);
      op(1'b1, 3'd1, 8'h00, 8'h00, 1'b0, 1'b0);
      check("chain_q_b", longint'(q2), longint'(8'h01));
      check("chain_q_a", longint'(q1), longint'(8'h00));

`ifdef UNIV_SHIFT_REG_PARITY_EN
      op(1'b1, 3'd5, 8'h07, 8'h03, 1'b0, 1'b0);
      check("par_07", longint'(par1), 1);
      check("par_03", longint'(par2), 0);
`endif

      // Randomised operations with occasional enable drops and resets
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end else begin
            op(($urandom_range(0, 5) != 0), 3'($urandom_range(0, 7)),
               8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
         end
      end

      chk_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
